// File: rtl/chiplet_link_pkg.sv
// Shared types and sizing helpers for the chiplet link transmit/receive path.
package chiplet_link_pkg;

    typedef enum logic {
        IDLE  = 1'b0,
        SHIFT = 1'b1
    } tx_state_e;

    // Number of Lanes-bit beats needed to carry one Width-bit word.
    function automatic int unsigned beats_per_word(input int unsigned width,
                                                   input int unsigned lanes);
        return width / lanes;
    endfunction

endpackage

// File: rtl/link_credit_counter.sv
// Receiver credit counter: one credit taken per word sent, one returned per
// word drained by the far side. Saturates at Credits and flags over-return.
module link_credit_counter #(
    parameter int unsigned Credits = 4,
    parameter int unsigned CntW    = $clog2(Credits + 1)
) (
    input  logic            i_clk,
    input  logic            i_rst,
    input  logic            i_take,
    input  logic            i_return,
    output logic [CntW-1:0] o_count,
    output logic            o_err
);

    logic [CntW-1:0] count_q, count_d;
    logic            err_q, err_d;

    // Next count: take and return in the same cycle cancel out.
    always_comb begin
        count_d = count_q;
        err_d   = err_q;
        if (i_take && !i_return) begin
            if (count_q != '0) begin
                count_d = count_q - CntW'(1);
            end
        end else if (i_return && !i_take) begin
            if (count_q == CntW'(Credits)) begin
                err_d = 1'b1;
            end else begin
                count_d = count_q + CntW'(1);
            end
        end
    end

    // Count register; error flag is sticky until reset.
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            count_q <= CntW'(Credits);
            err_q   <= 1'b0;
        end else begin
            count_q <= count_d;
            err_q   <= err_d;
        end
    end

    assign o_count = count_q;
    assign o_err   = err_q;

endmodule

// File: rtl/link_tx_serializer.sv
// Transmit serializer: pops words from a show-ahead FIFO when a receiver
// credit is available and sends them LSB-first as Lanes-bit beats with
// start/end-of-word markers. Back-to-back words stream without a bubble.
module link_tx_serializer
    import chiplet_link_pkg::*;
#(
    parameter int unsigned Width   = 32,
    parameter int unsigned Lanes   = 8,
    parameter int unsigned Credits = 4
) (
    input  logic                         i_clk,
    input  logic                         i_rst,
    input  logic                         i_fifo_empty,
    output logic                         o_fifo_read,
    input  logic [Width-1:0]             i_fifo_rdata,
    output logic                         o_tx_valid,
    output logic [Lanes-1:0]             o_tx_data,
    output logic                         o_tx_sof,
    output logic                         o_tx_eof,
    input  logic                         i_credit_return,
    output logic [$clog2(Credits+1)-1:0] o_credits,
    output logic                         o_credit_err,
    output logic                         o_busy
);

    localparam int unsigned Beats = beats_per_word(Width, Lanes);
    localparam int unsigned BW    = $clog2(Beats);
    localparam int unsigned CntW  = $clog2(Credits + 1);

    tx_state_e        state_q, state_d;
    logic [Width-1:0] shift_q, shift_d;
    logic [BW-1:0]    beat_q, beat_d;
    logic             valid_q, valid_d;
    logic             sof_q, sof_d;
    logic             eof_q, eof_d;
    logic             last_beat;
    logic             load;
    logic [CntW-1:0]  credits;

    link_credit_counter #(
        .Credits (Credits),
        .CntW    (CntW)
    ) u_credits (
        .i_clk    (i_clk),
        .i_rst    (i_rst),
        .i_take   (load),
        .i_return (i_credit_return),
        .o_count  (credits),
        .o_err    (o_credit_err)
    );

    // Pop decision uses the registered credit count only.
    always_comb begin
        last_beat = (state_q == SHIFT) && (beat_q == '0);
        load      = !i_fifo_empty && (credits != '0)
                    && ((state_q == IDLE) || last_beat);
    end

    // Next-state logic; sof/eof/valid are precomputed so the link outputs
    // come straight from flops.
    always_comb begin
        state_d = state_q;
        shift_d = shift_q;
        beat_d  = beat_q;
        valid_d = valid_q;
        sof_d   = 1'b0;
        eof_d   = 1'b0;
        if (load) begin
            state_d = SHIFT;
            shift_d = i_fifo_rdata;
            beat_d  = BW'(Beats - 1);
            valid_d = 1'b1;
            sof_d   = 1'b1;
        end else if (state_q == SHIFT) begin
            shift_d = shift_q >> Lanes;
            if (last_beat) begin
                state_d = IDLE;
                beat_d  = '0;
                valid_d = 1'b0;
            end else begin
                beat_d  = beat_q - BW'(1);
                valid_d = 1'b1;
                eof_d   = (beat_q == BW'(1));
            end
        end else begin
            valid_d = 1'b0;
        end
    end

    // Serializer FSM and output registers.
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            state_q <= IDLE;
            shift_q <= '0;
            beat_q  <= '0;
            valid_q <= 1'b0;
            sof_q   <= 1'b0;
            eof_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            shift_q <= shift_d;
            beat_q  <= beat_d;
            valid_q <= valid_d;
            sof_q   <= sof_d;
            eof_q   <= eof_d;
        end
    end

    // The shift register drains to zero on the final beat, so the data
    // lanes are quiet whenever the FSM is idle.
    assign o_fifo_read = load;
    assign o_tx_valid  = valid_q;
    assign o_tx_data   = shift_q[Lanes-1:0];
    assign o_tx_sof    = sof_q;
    assign o_tx_eof    = eof_q;
    assign o_busy      = (state_q == SHIFT);
    assign o_credits   = credits;

endmodule

// File: tb/tb_link_tx_serializer.sv
// Directed bench for link_tx_serializer (Width=32, Lanes=8, Credits=4).
module tb_link_tx_serializer;

    logic        clk;
    logic        rst;
    logic        fifo_empty;
    logic        fifo_read;
    logic [31:0] fifo_rdata;
    logic        tx_valid;
    logic [7:0]  tx_data;
    logic        tx_sof;
    logic        tx_eof;
    logic        credit_return;
    logic [2:0]  credits;
    logic        credit_err;
    logic        busy;

    int checks;
    int failures;
    logic [31:0] fifo_q[$];

    link_tx_serializer #(
        .Width   (32),
        .Lanes   (8),
        .Credits (4)
    ) dut (
        .i_clk           (clk),
        .i_rst           (rst),
        .i_fifo_empty    (fifo_empty),
        .o_fifo_read     (fifo_read),
        .i_fifo_rdata    (fifo_rdata),
        .o_tx_valid      (tx_valid),
        .o_tx_data       (tx_data),
        .o_tx_sof        (tx_sof),
        .o_tx_eof        (tx_eof),
        .i_credit_return (credit_return),
        .o_credits       (credits),
        .o_credit_err    (credit_err),
        .o_busy          (busy)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Present the FIFO head to the DUT and let combinational outputs settle.
    task automatic drive(input logic ret);
        fifo_empty    = (fifo_q.size() == 0);
        fifo_rdata    = (fifo_q.size() == 0) ? 32'h0 : fifo_q[0];
        credit_return = ret;
        #1;
    endtask

    // Advance one clock: the FIFO model pops on the same edge as the DUT.
    task automatic adv();
        if (fifo_read && fifo_q.size() != 0) void'(fifo_q.pop_front());
        @(negedge clk);
        credit_return = 1'b0;
    endtask

    task automatic idle_cycles(input int n);
        for (int k = 0; k < n; k++) begin
            drive(1'b0);
            adv();
        end
    endtask

    task automatic return_credits(input int n);
        for (int k = 0; k < n; k++) begin
            drive(1'b1);
            adv();
        end
        drive(1'b0);
    endtask

    int t;
    int reads;
    int beats;

    initial begin
        checks        = 0;
        failures      = 0;
        rst           = 1'b0;
        fifo_empty    = 1'b1;
        fifo_rdata    = 32'h0;
        credit_return = 1'b0;
        #2 rst = 1'b1;
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;

        // Reset state
        drive(1'b0);
        chk("rst_valid", 32'(tx_valid), 32'h0);
        chk("rst_data", 32'(tx_data), 32'h0);
        chk("rst_sof_eof", {30'h0, tx_sof, tx_eof}, 32'h0);
        chk("rst_busy", 32'(busy), 32'h0);
        chk("rst_read", 32'(fifo_read), 32'h0);
        chk("rst_credits", 32'(credits), 32'd4);
        chk("rst_err", 32'(credit_err), 32'h0);
        adv();

        // Single word
        fifo_q.push_back(32'hDDCCBBAA);
        drive(1'b0);
        chk("w1_read", 32'(fifo_read), 32'h1);
        chk("w1_cred_before", 32'(credits), 32'd4);
        adv();
        drive(1'b0);
        chk("w1_read_once", 32'(fifo_read), 32'h0);
        chk("w1_cred_after", 32'(credits), 32'd3);
        chk("w1_b0", {22'h0, tx_valid, tx_sof, tx_eof, tx_data}, {22'h0, 3'b110, 8'hAA});
        adv();
        drive(1'b0);
        chk("w1_b1", {22'h0, tx_valid, tx_sof, tx_eof, tx_data}, {22'h0, 3'b100, 8'hBB});
        adv();
        drive(1'b0);
        chk("w1_b2", {22'h0, tx_valid, tx_sof, tx_eof, tx_data}, {22'h0, 3'b100, 8'hCC});
        adv();
        drive(1'b0);
        chk("w1_b3", {22'h0, tx_valid, tx_sof, tx_eof, tx_data}, {22'h0, 3'b101, 8'hDD});
        chk("w1_busy", 32'(busy), 32'h1);
        adv();
        drive(1'b0);
        chk("w1_end", {22'h0, tx_valid, tx_sof, tx_eof, tx_data}, 32'h0);
        chk("w1_end_busy", 32'(busy), 32'h0);
        return_credits(1);
        chk("w1_cred_back", 32'(credits), 32'd4);
        chk("w1_no_err", 32'(credit_err), 32'h0);

        // Three back-to-back words: beat b carries byte b+1
        fifo_q.push_back(32'h04030201);
        fifo_q.push_back(32'h08070605);
        fifo_q.push_back(32'h0C0B0A09);
        for (int i = 0; i <= 13; i++) begin
            drive(1'b0);
            chk($sformatf("b2b_read_%0d", i), 32'(fifo_read),
                32'((i == 0) || (i == 4) || (i == 8)));
            if (i >= 1 && i <= 12) begin
                chk($sformatf("b2b_beat_%0d", i),
                    {22'h0, tx_valid, tx_sof, tx_eof, tx_data},
                    {22'h0, 1'b1, ((i - 1) % 4) == 0, ((i - 1) % 4) == 3, 8'(i)});
            end
            if (i == 13) begin
                chk("b2b_idle", 32'(tx_valid), 32'h0);
                chk("b2b_credits", 32'(credits), 32'd1);
            end
            adv();
        end
        return_credits(3);
        chk("b2b_cred_back", 32'(credits), 32'd4);

        // Six words, no returns: credits stall the stream after four
        for (int k = 0; k < 6; k++) fifo_q.push_back({4{8'(8'h10 + k)}});
        reads = 0;
        beats = 0;
        for (int i = 0; i < 20; i++) begin
            drive(1'b0);
            if (fifo_read) reads++;
            if (tx_valid) beats++;
            adv();
        end
        drive(1'b0);
        chk("stall_reads", 32'(reads), 32'd4);
        chk("stall_beats", 32'(beats), 32'd16);
        chk("stall_state", {29'h0, tx_valid, busy, fifo_read}, 32'h0);
        chk("stall_credits", 32'(credits), 32'd0);
        chk("stall_left", 32'(fifo_q.size()), 32'd2);
        // Return at T: no pop yet (registered count)
        drive(1'b1);
        chk("ret_T_read", 32'(fifo_read), 32'h0);
        chk("ret_T_cred", 32'(credits), 32'd0);
        adv();
        // T+1: credit visible, pop
        drive(1'b0);
        chk("ret_T1_cred", 32'(credits), 32'd1);
        chk("ret_T1_read", 32'(fifo_read), 32'h1);
        adv();
        // T+2: first beat of word 4, return one credit
        drive(1'b1);
        chk("ret_T2_beat", {22'h0, tx_valid, tx_sof, tx_eof, tx_data}, {22'h0, 3'b110, 8'h14});
        chk("ret_T2_cred", 32'(credits), 32'd0);
        adv();
        // T+3: return another
        drive(1'b1);
        chk("ret_T3_cred", 32'(credits), 32'd1);
        adv();
        drive(1'b0);
        chk("ret_T4_cred", 32'(credits), 32'd2);
        adv();
        // T+5: last beat with pop, plus a simultaneous return
        drive(1'b1);
        chk("same_eof", 32'(tx_eof), 32'h1);
        chk("same_read", 32'(fifo_read), 32'h1);
        chk("same_cred_before", 32'(credits), 32'd2);
        adv();
        drive(1'b0);
        chk("same_cred_after", 32'(credits), 32'd2);
        chk("same_next_sof", {23'h0, tx_sof, tx_data}, {23'h0, 1'b1, 8'h15});
        adv();
        idle_cycles(4);
        chk("drain_idle", 32'(tx_valid), 32'h0);
        chk("drain_cred", 32'(credits), 32'd2);
        return_credits(2);
        chk("drain_cred_back", 32'(credits), 32'd4);

        // Over-return while idle and full
        chk("err_before", 32'(credit_err), 32'h0);
        return_credits(1);
        chk("err_cred_sat", 32'(credits), 32'd4);
        chk("err_set", 32'(credit_err), 32'h1);
        fifo_q.push_back(32'hA5A5A5A5);
        idle_cycles(6);
        chk("err_sticky", 32'(credit_err), 32'h1);
        chk("err_cred_after", 32'(credits), 32'd3);

        // Reset after the second beat of a word
        fifo_q.push_back(32'h44332211);
        drive(1'b0);
        chk("rstm_read", 32'(fifo_read), 32'h1);
        adv();
        drive(1'b0);
        chk("rstm_b0", 32'(tx_data), 32'h11);
        adv();
        drive(1'b0);
        chk("rstm_b1", 32'(tx_data), 32'h22);
        chk("rstm_cred_pre", 32'(credits), 32'd2);
        rst = 1'b1;
        #1;
        chk("rstm_valid", 32'(tx_valid), 32'h0);
        chk("rstm_data", 32'(tx_data), 32'h0);
        chk("rstm_credits", 32'(credits), 32'd4);
        chk("rstm_err", 32'(credit_err), 32'h0);
        adv();
        rst = 1'b0;
        beats = 0;
        for (int i = 0; i < 4; i++) begin
            drive(1'b0);
            if (tx_valid || fifo_read) beats++;
            adv();
        end
        chk("rstm_quiet", 32'(beats), 32'd0);
        fifo_q.push_back(32'h88776655);
        drive(1'b0);
        chk("rstm_new_read", 32'(fifo_read), 32'h1);
        adv();
        drive(1'b0);
        chk("rstm_new_sof", {22'h0, tx_valid, tx_sof, tx_eof, tx_data}, {22'h0, 3'b110, 8'h55});
        adv();
        t = 0;

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
